// File: rtl/sonar_echo_emu.sv
// sonar_echo_emu: responder side of an HC-SR04 style trig/echo link.
// A trigger held for at least TRIG_MIN_US is answered, after a fixed burst
// delay, with an echo pulse whose width encodes dist_cm. An out-of-range
// distance gives a timeout-width echo. After the echo there is a holdoff.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   trig            trigger from controller (asynchronous, synchronized here)
//   dist_cm [8:0]   emulated distance, captured when a trigger is accepted
//   ech             registered echo pulse
//   busy            high from trigger acceptance until holdoff ends
//   done            one-cycle pulse on the cycle ech falls
//   short_trig      one-cycle pulse when a too-short trigger is rejected
module sonar_echo_emu #(
  parameter int clk_freq    = 1_000_000,
  parameter int TRIG_MIN_US = 10,
  parameter int BURST_US    = 200,
  parameter int US_PER_CM   = 58,
  parameter int MIN_CM      = 2,
  parameter int MAX_CM      = 400,
  parameter int TIMEOUT_US  = 38000,
  parameter int HOLDOFF_US  = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trig,
  input  logic [8:0] dist_cm,
  output logic       ech,
  output logic       busy,
  output logic       done,
  output logic       short_trig
);

  localparam int CPU    = clk_freq / 1_000_000;
  localparam int TMIN   = TRIG_MIN_US * CPU;
  localparam int BCYC   = BURST_US * CPU;
  localparam int HCYC   = HOLDOFF_US * CPU;
  localparam int WIN    = MAX_CM * US_PER_CM * CPU;
  localparam int WTO    = TIMEOUT_US * CPU;
  localparam int WMAX   = (WIN > WTO) ? WIN : WTO;
  localparam int M1     = (WMAX > BCYC) ? WMAX : BCYC;
  localparam int M2     = (M1 > HCYC) ? M1 : HCYC;
  localparam int CMAX   = (M2 > TMIN) ? M2 : TMIN;
  localparam int CW     = $clog2(CMAX + 1);

  localparam logic [CW-1:0] TMIN_C   = CW'(TMIN);
  localparam logic [CW-1:0] BLAST_C  = CW'(BCYC - 1);
  localparam logic [CW-1:0] HCYC_C   = CW'(HCYC);
  localparam logic [CW-1:0] WTO_C    = CW'(WTO);
  localparam logic [CW-1:0] PERCM_C  = CW'(US_PER_CM * CPU);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [CW-1:0] ARMLOW_C = CW'(2);

  typedef enum logic [2:0] {
    ARM, IDLE, TRIG_HI, BURST, ECHO, HOLDOFF
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] w_q;
  logic [CW-1:0] w_d;
  logic [8:0]    dist_cl;
  logic          trig_m_q, trig_s_q;
  logic          ech_q, busy_q, done_q, short_q;

  assign ech        = ech_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign short_trig = short_q;

  // Echo width for the current dist_cm: clamp low, timeout when above range.
  always_comb begin
    dist_cl = dist_cm;
    if (dist_cm < 9'(MIN_CM)) dist_cl = 9'(MIN_CM);
    if (dist_cm > 9'(MAX_CM)) w_d = WTO_C;
    else                      w_d = CW'(dist_cl) * PERCM_C;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARM;
      cnt_q    <= '0;
      w_q      <= '0;
      trig_m_q <= 1'b0;
      trig_s_q <= 1'b0;
      ech_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      short_q  <= 1'b0;
    end else begin
      trig_m_q <= trig;
      trig_s_q <= trig_m_q;
      done_q   <= 1'b0;
      short_q  <= 1'b0;
      case (state_q)
        // Require three consecutive low samples: the synchronizer comes out
        // of reset at 0, so a trig held high through reset only shows up on
        // trig_s two cycles later and must not be mistaken for "low".
        ARM: begin
          if (trig_s_q) begin
            cnt_q <= '0;
          end else if (cnt_q == ARMLOW_C) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + ONE_C;
          end
        end
        IDLE: begin
          if (trig_s_q) begin
            state_q <= TRIG_HI;
            cnt_q   <= ONE_C;
          end
        end
        TRIG_HI: begin
          if (trig_s_q) begin
            if (cnt_q < TMIN_C) cnt_q <= cnt_q + ONE_C;
          end else if (cnt_q >= TMIN_C) begin
            w_q     <= w_d;
            busy_q  <= 1'b1;
            state_q <= BURST;
            cnt_q   <= ONE_C;  // the trig_s falling edge cycle counts as 1
          end else begin
            short_q <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        end
        BURST: begin
          if (cnt_q == BLAST_C) begin
            ech_q   <= 1'b1;
            state_q <= ECHO;
            cnt_q   <= ONE_C;
          end else begin
            cnt_q <= cnt_q + ONE_C;
          end
        end
        ECHO: begin
          if (cnt_q == w_q) begin
            ech_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= HOLDOFF;
            cnt_q   <= ONE_C;
          end else begin
            cnt_q <= cnt_q + ONE_C;
          end
        end
        HOLDOFF: begin
          if (cnt_q == HCYC_C) begin
            busy_q  <= 1'b0;
            state_q <= ARM;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + ONE_C;
          end
        end
        default: begin
          state_q <= ARM;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule
